j_i2s_rx: RTL

I2S serial receiver for the Jerry audio path. It oversamples the external SCK/WS/SD pins on `sys_clk` and deserialises MSB-first words. It presents left and right words on parallel registers, with per-channel ready/ack handshakes and a one-cycle word strobe. The strobe is the load enable for the downstream clock-enabled word latches (mux-plus-flop slatch stage) that feed the DSP.

---
 rtl/j_i2s_rx.sv | 114 +++++++++++
 1 files changed

// File: rtl/j_i2s_rx.sv
// j_i2s_rx: oversampled I2S receiver, MSB-first words to left/right registers with ready/ack and a load strobe.
// Define J_I2S_RX_OVERRUN_EN to build the sticky lovr/rovr overrun flags; otherwise they read as 0.
module j_i2s_rx #(
  parameter int WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             en,
  input  logic             sck,
  input  logic             ws,
  input  logic             sd,
  output logic [WIDTH-1:0] ldata,
  output logic [WIDTH-1:0] rdata,
  output logic             lrdy,
  output logic             rrdy,
  input  logic             lack,
  input  logic             rack,
  output logic             wstb,
  output logic             wch,
  output logic             lovr,
  output logic             rovr
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic SYNC = 1'b0;
  localparam logic RUN = 1'b1;
  // Synchroniser stages packed as {sck, ws, sd}; only sck needs the history stage.
  logic [2:0] s1_q, s2_q;
  logic s3_q;
  logic state_q, state_d, wsp_q, wsp_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, ldata_q, ldata_d, rdata_q, rdata_d, mask, word;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lrdy_q, lrdy_d, rrdy_q, rrdy_d, wstb_q, wstb_d, wch_q, wch_d;
  logic rise, bdry, run, ld, lld, rld;
  always_comb begin
    rise = s2_q[2] & ~s3_q;
    bdry = rise & (s2_q[1] != wsp_q);
    run = en & (state_q == RUN);
    ld = run & bdry;
    lld = ld & ~wsp_q;
    rld = ld & wsp_q;
    // Shifting past the LSB leaves mask at 0, so overlong words drop their extra bits.
    mask = {1'b1, {(WIDTH-1){1'b0}}} >> cnt_q;
    word = shreg_q | (s2_q[0] ? mask : '0);
    state_d = !en ? SYNC : (bdry ? RUN : state_q);
    wsp_d = rise ? s2_q[1] : wsp_q;
    shreg_d = bdry ? '0 : ((run & rise) ? word : shreg_q);
    cnt_d = bdry ? '0 : ((run & rise) ? cnt_q + CW'(cnt_q != CW'(WIDTH)) : cnt_q);
    ldata_d = lld ? word : ldata_q;
    rdata_d = rld ? word : rdata_q;
    lrdy_d = lld | (lrdy_q & ~lack);
    rrdy_d = rld | (rrdy_q & ~rack);
    wstb_d = ld;
    wch_d = ld ? wsp_q : wch_q;
  end
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= 1'b0;
      state_q <= SYNC;
      wsp_q <= 1'b0;
      shreg_q <= '0;
      cnt_q <= '0;
      ldata_q <= '0;
      rdata_q <= '0;
      lrdy_q <= 1'b0;
      rrdy_q <= 1'b0;
      wstb_q <= 1'b0;
      wch_q <= 1'b0;
    end else begin
      s1_q <= {sck, ws, sd};
      s2_q <= s1_q;
      s3_q <= s2_q[2];
      state_q <= state_d;
      wsp_q <= wsp_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
      ldata_q <= ldata_d;
      rdata_q <= rdata_d;
      lrdy_q <= lrdy_d;
      rrdy_q <= rrdy_d;
      wstb_q <= wstb_d;
      wch_q <= wch_d;
    end
  end
  assign ldata = ldata_q;
  assign rdata = rdata_q;
  assign lrdy = lrdy_q;
  assign rrdy = rrdy_q;
  assign wstb = wstb_q;
  assign wch = wch_q;
`ifdef J_I2S_RX_OVERRUN_EN
  logic lovr_q, lovr_d, rovr_q, rovr_d;
  // A same-cycle ack both keeps the flag clear and wins over a fresh overrun.
  always_comb begin
    lovr_d = ((lld & lrdy_q) | lovr_q) & ~lack;
    rovr_d = ((rld & rrdy_q) | rovr_q) & ~rack;
  end
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      lovr_q <= 1'b0;
      rovr_q <= 1'b0;
    end else begin
      lovr_q <= lovr_d;
      rovr_q <= rovr_d;
    end
  end
  assign lovr = lovr_q;
  assign rovr = rovr_q;
`else
  assign lovr = 1'b0;
  assign rovr = 1'b0;
`endif
endmodule
